// File: rtl/ddr3_usr_write_logic_if.sv
// ddr3_usr_write_logic_if: EMIF Avalon-style write command port.
interface ddr3_usr_write_logic_if;
  logic         ddr3_emif_ready;
  logic         ddr3_emif_write;
  logic         ddr3_emif_read;
  logic [21:0]  ddr3_emif_addr;
  logic [255:0] ddr3_emif_write_data;
  logic [31:0]  ddr3_emif_byte_enable;
  logic [4:0]   ddr3_emif_burst_count;
  modport master (
    input  ddr3_emif_ready,
    output ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr,
    output ddr3_emif_write_data, ddr3_emif_byte_enable, ddr3_emif_burst_count
  );
  modport slave (
    output ddr3_emif_ready,
    input  ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr,
    input  ddr3_emif_write_data, ddr3_emif_byte_enable, ddr3_emif_burst_count
  );
endinterface

// File: rtl/ddr3_usr_write_logic.sv
// ddr3_usr_write_logic: realigns a byte-packed 256-bit stream to an unaligned DDR3 byte address and writes it via EMIF.
module ddr3_usr_write_logic (
  input  logic                          ddr3_emif_clk,
  input  logic                          ddr3_emif_rst,
  ddr3_usr_write_logic_if.master        emif,
  input  logic [26:0]                   ddr3_usr_start_addr_in,
  input  logic [31:0]                   to_write_byte_in,
  input  logic                          ddr3_write_start,
  output logic                          ddr3_write_busy_out,
  output logic                          ddr3_write_done_out,
  input  logic [255:0]                  write_data_in,
  input  logic                          write_data_valid_in,
  output logic                          write_ready_out
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [4:0] offset, lo;
  logic first, first_n, done_q;
  logic [32:0] bytes_left, bytes_n;
  logic [27:0] beats_left;
  logic [255:0] residue, data_q, word_n;
  logic [511:0] cat;
  logic [31:0] be_q, be_n;
  logic [21:0] addr_q;
  logic start_ok, zero_len, beat_acc, wr_acc, more_words, more_beats;
  assign start_ok = state == IDLE && ddr3_write_start;
  assign zero_len = to_write_byte_in == 32'd0;
  assign more_words = bytes_left > 33'd32;
  assign more_beats = beats_left != 28'd0;
  assign wr_acc = state == WRITE && emif.ddr3_emif_ready;
  assign write_ready_out = state == LOAD || (wr_acc && more_beats);
  assign beat_acc = write_ready_out && write_data_valid_in;
  // A word formed in the same cycle the previous one is accepted belongs to the next position.
  assign bytes_n = wr_acc ? bytes_left - 33'd32 : bytes_left;
  assign first_n = first && !wr_acc;
  assign lo = first_n ? offset : 5'd0;
  assign cat = {residue, state == FLUSH ? 256'd0 : write_data_in};
  assign word_n = cat[{offset, 3'b000} +: 256];
  for (genvar k = 0; k < 32; k++) begin : g_be
    assign be_n[31-k] = 5'(k) >= lo && 33'(k) < bytes_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_ok && !zero_len ? LOAD : IDLE;
      LOAD:    state_n = beat_acc ? WRITE : LOAD;
      WRITE:   state_n = !wr_acc ? WRITE : !more_words ? DONE : !more_beats ? FLUSH : beat_acc ? WRITE : LOAD;
      FLUSH:   state_n = WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ddr3_emif_clk) state <= ddr3_emif_rst ? IDLE : state_n;
  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      offset <= '0;
      first <= 1'b0;
      done_q <= 1'b0;
      bytes_left <= '0;
      beats_left <= '0;
      residue <= '0;
      data_q <= '0;
      be_q <= '0;
      addr_q <= '0;
    end else begin
      done_q <= (start_ok && zero_len) || (wr_acc && !more_words);
      if (start_ok) begin
        offset <= ddr3_usr_start_addr_in[4:0];
        addr_q <= ddr3_usr_start_addr_in[26:5];
        first <= 1'b1;
        bytes_left <= {28'd0, ddr3_usr_start_addr_in[4:0]} + {1'b0, to_write_byte_in};
        beats_left <= {1'b0, to_write_byte_in[31:5]} + 28'(|to_write_byte_in[4:0]);
      end
      if (wr_acc) begin
        addr_q <= addr_q + 22'd1;
        bytes_left <= bytes_n;
        first <= 1'b0;
      end
      if (beat_acc) begin
        residue <= write_data_in;
        beats_left <= beats_left - 28'd1;
      end
      if (beat_acc || state == FLUSH) begin
        data_q <= word_n;
        be_q <= be_n;
      end
    end
  end
  assign emif.ddr3_emif_write = state == WRITE;
  assign emif.ddr3_emif_read = 1'b0;
  assign emif.ddr3_emif_addr = addr_q;
  assign emif.ddr3_emif_write_data = data_q;
  assign emif.ddr3_emif_byte_enable = be_q;
  assign emif.ddr3_emif_burst_count = 5'd1;
  assign ddr3_write_busy_out = state != IDLE;
  assign ddr3_write_done_out = done_q;
endmodule

// File: tb/tb_ddr3_usr_write_logic.sv
// tb_ddr3_usr_write_logic: directed stimulus with a write scoreboard for ddr3_usr_write_logic.
module tb_ddr3_usr_write_logic;
  logic clk = 1'b0;
  logic rst;
  logic [26:0] start_addr;
  logic [31:0] nbytes;
  logic start, valid, busy, done, wready;
  logic [255:0] wdata;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [21:0] oa[$], ea[$];
  logic [31:0] ob[$], eb[$];
  logic [255:0] od[$], ed[$];
  ddr3_usr_write_logic_if emif();
  ddr3_usr_write_logic dut (
    .ddr3_emif_clk(clk),
    .ddr3_emif_rst(rst),
    .emif(emif.master),
    .ddr3_usr_start_addr_in(start_addr),
    .to_write_byte_in(nbytes),
    .ddr3_write_start(start),
    .ddr3_write_busy_out(busy),
    .ddr3_write_done_out(done),
    .write_data_in(wdata),
    .write_data_valid_in(valid),
    .write_ready_out(wready)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  always @(negedge clk) begin
    cyc++;
    if (!rst && emif.ddr3_emif_write && emif.ddr3_emif_ready) begin
      oa.push_back(emif.ddr3_emif_addr);
      ob.push_back(emif.ddr3_emif_byte_enable);
      od.push_back(emif.ddr3_emif_write_data);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] sb(input logic [7:0] seed, input int i);
    return 8'(int'(seed) + i);
  endfunction
  function automatic logic [255:0] beat_of(input logic [7:0] seed, input int b);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = sb(seed, 32*b + i);
    return d;
  endfunction
  function automatic logic [255:0] mask_of(input logic [31:0] be);
    logic [255:0] m;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction
  task automatic clr();
    oa.delete(); ob.delete(); od.delete();
    ea.delete(); eb.delete(); ed.delete();
  endtask
  task automatic exp_push(input logic [21:0] a, input logic [31:0] be, input logic [255:0] d);
    ea.push_back(a); eb.push_back(be); ed.push_back(d);
  endtask
  // Byte-level reference: global position g = 32w+k carries stream byte g-o when inside the window.
  task automatic model(input logic [26:0] sa, input int n, input logic [7:0] seed);
    int o, wc, g;
    logic [255:0] d;
    logic [31:0] be;
    o = int'(sa[4:0]);
    wc = (o + n + 31) / 32;
    for (int w = 0; w < wc; w++) begin
      d = '0; be = '0;
      for (int k = 0; k < 32; k++) begin
        g = 32*w + k;
        if (g >= o && g < o + n) begin
          be[31-k] = 1'b1;
          d[255-8*k -: 8] = sb(seed, g - o);
        end
      end
      exp_push(22'(int'(sa[26:5]) + w), be, d);
    end
  endtask
  task automatic cmp_writes(input string tag);
    check({tag, "_nwr"}, 256'(oa.size()), 256'(ea.size()));
    for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
      check({tag, "_addr"}, 256'(oa[i]), 256'(ea[i]));
      check({tag, "_be"}, 256'(ob[i]), 256'(eb[i]));
      check({tag, "_data"}, od[i] & mask_of(eb[i]), ed[i] & mask_of(eb[i]));
    end
  endtask
  task automatic run_op(input logic [26:0] sa, input logic [31:0] n, input logic [7:0] seed,
                        input int stall_at, input int stall_len, input int bstart_at,
                        input int exp_iters, input string tag);
    int nb, bi, it;
    logic done_seen, acc, prev_stall;
    logic [21:0] h_addr;
    logic [31:0] h_be;
    logic [255:0] h_data;
    nb = int'((n + 32'd31) / 32'd32);
    @(posedge clk); #1;
    start_addr = sa; nbytes = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bi = 0; it = 0; done_seen = 1'b0; prev_stall = 1'b0;
    while (!done_seen && it < 200) begin
      valid = bi < nb;
      wdata = beat_of(seed, bi);
      emif.ddr3_emif_ready = !(it >= stall_at && it < stall_at + stall_len);
      start = it == bstart_at;
      if (start) begin start_addr = 27'h0; nbytes = 32'd8; end
      @(negedge clk);
      if (it == 0) begin
        check({tag, "_busy_rise"}, 256'(busy), 256'(1));
        check({tag, "_ready_rise"}, 256'(wready), 256'(1));
      end
      if (!emif.ddr3_emif_ready && emif.ddr3_emif_write) begin
        check({tag, "_stall_rdy"}, 256'(wready), 256'(0));
        if (prev_stall) begin
          check({tag, "_hold_addr"}, 256'(emif.ddr3_emif_addr), 256'(h_addr));
          check({tag, "_hold_be"}, 256'(emif.ddr3_emif_byte_enable), 256'(h_be));
          check({tag, "_hold_data"}, emif.ddr3_emif_write_data, h_data);
        end
        prev_stall = 1'b1;
        h_addr = emif.ddr3_emif_addr;
        h_be = emif.ddr3_emif_byte_enable;
        h_data = emif.ddr3_emif_write_data;
      end else prev_stall = 1'b0;
      acc = valid && wready;
      done_seen = done;
      @(posedge clk); #1;
      if (acc) bi++;
      it++;
    end
    start = 1'b0; valid = 1'b0; emif.ddr3_emif_ready = 1'b1;
    check({tag, "_done"}, 256'(done_seen), 256'(1));
    if (exp_iters >= 0) check({tag, "_cycles"}, 256'(it - 1), 256'(exp_iters));
    check({tag, "_beats"}, 256'(bi), 256'(nb));
    check({tag, "_done_lat"}, 256'(done_cyc - last_wr_cyc), 256'(1));
    @(negedge clk);
    check({tag, "_busy_fall"}, 256'(busy), 256'(0));
    check({tag, "_done_once"}, 256'(done), 256'(0));
    cmp_writes(tag);
  endtask
  initial begin
    logic [255:0] u0, u1;
    int d0;
    rst = 1'b1; start = 1'b0; valid = 1'b0; start_addr = '0; nbytes = '0; wdata = '0;
    emif.ddr3_emif_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write", 256'(emif.ddr3_emif_write), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_wready", 256'(wready), 256'(0));
    check("rst_addr", 256'(emif.ddr3_emif_addr), 256'(0));
    check("rst_data", emif.ddr3_emif_write_data, 256'(0));
    check("rst_be", 256'(emif.ddr3_emif_byte_enable), 256'(0));
    check("rst_burst", 256'(emif.ddr3_emif_burst_count), 256'(1));
    check("rst_read", 256'(emif.ddr3_emif_read), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; emif.ddr3_emif_ready = 1'b1;
    clr();
    exp_push(22'd2, '1, beat_of(8'h80, 0));
    exp_push(22'd3, '1, beat_of(8'h80, 1));
    run_op(27'h40, 32'd64, 8'h80, -1, 0, -1, 3, "aligned");
    clr();
    u0 = '0; u1 = '0;
    for (int k = 3; k < 32; k++) u0[255-8*k -: 8] = 8'(k - 3);
    for (int k = 0; k < 3; k++) u1[255-8*k -: 8] = 8'(29 + k);
    exp_push(22'd1, 32'h1FFFFFFF, u0);
    exp_push(22'd2, 32'hE0000000, u1);
    run_op(27'h23, 32'd32, 8'h00, -1, 0, -1, 4, "unaligned");
    clr();
    exp_push(22'd0, '1, beat_of(8'h55, 0));
    exp_push(22'd1, 32'hFF000000, beat_of(8'h55, 1));
    run_op(27'h0, 32'd40, 8'h55, -1, 0, -1, 3, "tail");
    clr();
    model(27'h105, 100, 8'h11);
    run_op(27'h105, 32'd100, 8'h11, 2, 5, -1, -1, "backpressure");
    clr();
    d0 = done_cnt;
    @(posedge clk); #1;
    start_addr = 27'h100; nbytes = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("n0_done", 256'(done), 256'(1));
    check("n0_busy", 256'(busy), 256'(0));
    @(negedge clk);
    check("n0_done_once", 256'(done), 256'(0));
    check("n0_busy_after", 256'(busy), 256'(0));
    repeat (3) @(negedge clk);
    check("n0_nwr", 256'(oa.size()), 256'(0));
    check("n0_done_cnt", 256'(done_cnt), 256'(d0 + 1));
    clr();
    model(27'h209, 50, 8'h40);
    run_op(27'h209, 32'd50, 8'h40, -1, 0, 2, 3, "busy_start");
    clr();
    d0 = done_cnt;
    @(posedge clk); #1;
    start_addr = 27'h0; nbytes = 32'd96; start = 1'b1; emif.ddr3_emif_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; wdata = beat_of(8'h22, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("rstmid_write_pre", 256'(emif.ddr3_emif_write), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_write", 256'(emif.ddr3_emif_write), 256'(0));
    check("rstmid_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; emif.ddr3_emif_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_no_done", 256'(done_cnt), 256'(d0));
    check("rstmid_nwr", 256'(oa.size()), 256'(0));
    check("rstmid_idle", 256'(busy), 256'(0));
    clr();
    exp_push(22'h3FFFFF, '1, beat_of(8'hC0, 0));
    exp_push(22'h000000, '1, beat_of(8'hC0, 1));
    run_op(27'h7FFFFE0, 32'd64, 8'hC0, -1, 0, -1, 3, "wrap");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr3_usr_write_logic.md
# ddr3_usr_write_logic

Write-side companion of the DDR3 read path. It accepts a byte-packed 256-bit data stream from the upstream frame source and writes it into DDR3 through the EMIF Avalon-style port, starting at an arbitrary byte address. It realigns the stream to the unaligned start offset and generates byte enables for the first and last partial words. It raises a done pulse when the final word has been accepted.

## Interface
Parameters: none (widths fixed by the EMIF: 256-bit data, 22-bit word address).

- ddr3_emif_clk  in  1  sole clock
- ddr3_emif_rst  in  1  synchronous, active-high reset
- ddr3_emif_ready  in  1  EMIF accepts the presented command in any cycle where it is high
- ddr3_emif_write  out  1  write request
- ddr3_emif_read  out  1  constant 0
- ddr3_emif_addr  out  22  256-bit word address
- ddr3_emif_write_data  out  256  write data
- ddr3_emif_byte_enable  out  32  byte enables
- ddr3_emif_burst_count  out  5  constant 1
- ddr3_usr_start_addr_in  in  27  byte start address, sampled on start
- to_write_byte_in  in  32  total bytes N, sampled on start
- ddr3_write_start  in  1  start pulse; ignored unless idle
- ddr3_write_busy_out  out  1  operation in progress
- ddr3_write_done_out  out  1  one-cycle completion pulse
- write_data_in  in  256  input beat of 32 packed stream bytes
- write_data_valid_in  in  1  beat valid
- write_ready_out  out  1  beat accepted when valid and ready are both high

## Operation
- Byte order:
  - Byte k of a word occupies data[255-8k -: 8] and byte_enable[31-k].
  - Stream byte 0 is byte 0 of the first input beat.
- Offset o = start[4:0]. The first word address is start[26:5].
- Word count W = ceil((o+N)/32). Beat count B = ceil(N/32). W−B ∈ {0,1}.
  - Unused tail bytes of the last beat are ignored.
- Output word w, byte k, global position g = 32w+k:
  - k ≥ o: byte k−o of the current beat.
  - k < o: byte 32−o+k of the previous beat, held in a residue register.
  - byte_enable[31-k] = (o ≤ g < o+N).
- States:
  - IDLE: on start with N=0, pulse done and stay idle. On start with N>0, load registers and go to LOAD.
  - LOAD: on an accepted beat, form a word and go to WRITE.
  - WRITE: hold write=1 until ready. On acceptance, the address increments by 1 (22-bit wrap 0x3FFFFF→0). Next state:
    - words remaining and beats remaining → LOAD, or stay in WRITE if a beat is accepted in the same cycle;
    - words remaining and no beats remaining → FLUSH;
    - no words remaining → DONE.
  - FLUSH: present the residue-only word (positions < o), then go to WRITE.
  - DONE: pulse done, go to IDLE.
- Input acceptance: write_ready_out = (state==LOAD) or (state==WRITE and ddr3_emif_ready and another beat is still expected).
- A start pulse while busy is ignored.

## Timing
- Reset values:
  - ddr3_emif_write, ddr3_write_done_out, ddr3_write_busy_out, write_ready_out: 0.
  - ddr3_emif_addr, ddr3_emif_write_data, ddr3_emif_byte_enable: 0.
  - ddr3_emif_burst_count: 1. ddr3_emif_read: 0.
  - State returns to IDLE.
- Reset mid-operation: write drops the next cycle; residue and counters clear; no done pulse.
- Start sampled at edge T: busy and write_ready_out are high from T+1.
- Beat accepted at edge T: write=1 with data, byte enable and address valid from T+1.
- While write=1 and ready=0, write, addr, data and byte_enable hold stable and no beat is accepted.
- Sustained throughput is 1 word/cycle when valid and ready stay high.
- Final write accepted at edge T: done=1 during T+1 only; busy low from T+2.
- N=0: done the cycle after start; busy never rises; no write.

## Test plan
- Aligned: start=0x40, N=64, two beats with continuous ready → writes at addr 2 and 3, both byte_enable 0xFFFFFFFF, data equal to the beats; done one cycle after the second write.
- Unaligned with flush: start=0x23, N=32, one beat of bytes 0x00..0x1F:
  - addr 1, byte_enable 0x1FFFFFFF, positions 3..31 = 0x00..0x1C;
  - then addr 2, byte_enable 0xE0000000, positions 0..2 = 0x1D..0x1F;
  - then done.
- Partial tail: start=0x00, N=40 → two writes; the second has byte_enable 0xFF000000; tail bytes of the second beat are ignored.
- Backpressure: ready=0 for 5 cycles mid-transfer → write/addr/data/byte_enable stable, write_ready_out=0, no beat lost or duplicated; the scoreboard matches the memory image.
- N=0 and start-while-busy: N=0 → done pulse, zero writes. A second start during an active op → ignored; the original op completes unchanged.
- Reset mid-op and wrap: reset asserted during WRITE → write=0 the next cycle, no done pulse. A new op at start=0x7FFFFE0, N=64 → writes at 0x3FFFFF then 0x000000.
